// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave to asynchronous 16-bit SRAM bridge.
// Every output comes straight from a flop, so strobes are decoded from the next state.
module wb_sram_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [17:0] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [17:0] sram_a_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        sram_lb_n_o,
  output logic        sram_ub_n_o,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe_o,
  input  logic [15:0] sram_d_i
);

  // state | meaning
  // IDLE  | bus idle, strobes inactive, waiting for a request
  // RD    | CE/OE low for WAIT_CYCLES, data captured on the last cycle
  // RACK  | read acknowledge, strobes inactive
  // WS    | write setup: CE low, data driven, WE high
  // WP    | write pulse: WE low for WAIT_CYCLES
  // WH    | write hold: WE high, data still driven, acknowledge
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WS   = 3'd2;
  localparam logic [2:0] S_WP   = 3'd3;
  localparam logic [2:0] S_WH   = 3'd4;
  localparam logic [2:0] S_RACK = 3'd5;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [17:0] adr_q, adr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wdat_q, wdat_d;
  logic [15:0] rdat_q, rdat_d;
  logic        ack_q, ack_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d;
  logic        ub_n_q, ub_n_d;
  logic        d_oe_q, d_oe_d;
  logic        req;
  logic        active_d;

  assign req = wb_cyc_i & wb_stb_i & ~ack_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (req) begin
          adr_d = wb_adr_i;
          sel_d = wb_sel_i;
          if (wb_we_i) begin
            wdat_d  = wb_dat_i;
            state_d = S_WS;
          end else begin
            cnt_d   = WAIT_LAST;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q == 4'd0) begin
          rdat_d  = {(sel_q[1] ? sram_d_i[15:8] : 8'h00),
                     (sel_q[0] ? sram_d_i[7:0]  : 8'h00)};
          state_d = S_RACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WS: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        cnt_d   = WAIT_LAST;
        state_d = S_WP;
      end
      S_WP: begin
        if (!wb_cyc_i) abort_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_WH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WH:    state_d = S_IDLE;
      S_RACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe flops are loaded from the state being entered so they line up with state_q.
  always_comb begin
    active_d = (state_d == S_RD) || (state_d == S_WS) ||
               (state_d == S_WP) || (state_d == S_WH);
    ce_n_d   = ~active_d;
    oe_n_d   = (state_d != S_RD);
    we_n_d   = (state_d != S_WP);
    lb_n_d   = ~(active_d & sel_d[0]);
    ub_n_d   = ~(active_d & sel_d[1]);
    d_oe_d   = (state_d == S_WS) || (state_d == S_WP) || (state_d == S_WH);
    ack_d    = ((state_d == S_RACK) || (state_d == S_WH)) && !abort_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      abort_q <= 1'b0;
      adr_q   <= 18'd0;
      sel_q   <= 2'b00;
      wdat_q  <= 16'h0000;
      rdat_q  <= 16'h0000;
      ack_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      d_oe_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      lb_n_q  <= lb_n_d;
      ub_n_q  <= ub_n_d;
      d_oe_q  <= d_oe_d;
    end
  end

  assign wb_dat_o    = rdat_q;
  assign wb_ack_o    = ack_q;
  assign sram_a_o    = adr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
  assign sram_lb_n_o = lb_n_q;
  assign sram_ub_n_o = ub_n_q;
  assign sram_d_o    = wdat_q;
  assign sram_d_oe_o = d_oe_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl at WAIT_CYCLES = 2, 1 and 15, each with its own SRAM model.
module tb_wb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mon_en = 1'b0;

  logic        cyc    [3];
  logic        stb    [3];
  logic        we     [3];
  logic [17:0] adr    [3];
  logic [1:0]  sel    [3];
  logic [15:0] dat_w  [3];
  logic [15:0] dat_r  [3];
  logic        ack    [3];
  logic [17:0] sram_a [3];
  logic        ce_n   [3];
  logic        oe_n   [3];
  logic        we_n   [3];
  logic        lb_n   [3];
  logic        ub_n   [3];
  logic [15:0] sram_do[3];
  logic        d_oe   [3];
  logic [15:0] sram_di[3];

  logic [15:0] mem [3][256];

  typedef struct {
    logic        rd;
    logic [15:0] data;
    int          lat;
    int          pulses;
  } txn_t;

  txn_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wb_sram_ctrl #(.WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .wb_cyc_i    (cyc[g]),
      .wb_stb_i    (stb[g]),
      .wb_we_i     (we[g]),
      .wb_adr_i    (adr[g]),
      .wb_sel_i    (sel[g]),
      .wb_dat_i    (dat_w[g]),
      .wb_dat_o    (dat_r[g]),
      .wb_ack_o    (ack[g]),
      .sram_a_o    (sram_a[g]),
      .sram_ce_n_o (ce_n[g]),
      .sram_oe_n_o (oe_n[g]),
      .sram_we_n_o (we_n[g]),
      .sram_lb_n_o (lb_n[g]),
      .sram_ub_n_o (ub_n[g]),
      .sram_d_o    (sram_do[g]),
      .sram_d_oe_o (d_oe[g]),
      .sram_d_i    (sram_di[g])
    );
  end

  // SRAM model: word index is the low 8 address bits, full address is checked separately.
  always_comb begin
    for (int i = 0; i < 3; i++)
      sram_di[i] = (!ce_n[i] && !oe_n[i]) ? mem[i][sram_a[i][7:0]] : 16'h0000;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 256; j++) mem[i][j] <= 16'h0000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!ce_n[i] && !we_n[i]) begin
          if (!lb_n[i]) mem[i][sram_a[i][7:0]][7:0]  <= sram_do[i][7:0];
          if (!ub_n[i]) mem[i][sram_a[i][7:0]][15:8] <= sram_do[i][15:8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("oe_we_overlap", {31'd0, (!oe_n[i] && !we_n[i])}, 32'd0);
        chk("doe_while_oe", {31'd0, (d_oe[i] && !oe_n[i])}, 32'd0);
      end
    end
  end

  task automatic access(input int i, input int w, input logic wr, input logic [17:0] a,
                        input logic [1:0] s, input logic [15:0] d, input logic [15:0] exp_rd);
    txn_t t;
    int   n;
    int   pulses;
    logic got;
    t.rd     = !wr;
    t.data   = exp_rd;
    t.lat    = wr ? w + 2 : w + 1;
    t.pulses = w;
    sb.push_back(t);
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = wr; adr[i] = a; sel[i] = s; dat_w[i] = d;
    @(posedge clk);
    n = 0; pulses = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (!ce_n[i]) begin
        chk("sram_addr", {14'd0, sram_a[i]}, {14'd0, a});
        chk("byte_en", {30'd0, ub_n[i], lb_n[i]}, {30'd0, ~s});
        if (d_oe[i]) chk("sram_wdata", {16'd0, sram_do[i]}, {16'd0, d});
      end
      if (wr ? !we_n[i] : !oe_n[i]) pulses++;
      if (ack[i]) got = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc[i] = 1'b0; stb[i] = 1'b0;
    t = sb.pop_front();
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", n, t.lat);
    chk("pulse_len", pulses, t.pulses);
    if (t.rd) chk("read_data", {16'd0, dat_r[i]}, {16'd0, t.data});
  endtask

  task automatic abort_read(input int i, input int w, input logic [17:0] a);
    int n_ack;
    int pulses;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; adr[i] = a; sel[i] = 2'b11;
    @(posedge clk);
    #1;
    cyc[i] = 1'b0; stb[i] = 1'b0;
    n_ack = 0; pulses = 0;
    for (int k = 0; k < w + 5; k++) begin
      @(negedge clk);
      if (ack[i]) n_ack++;
      if (!oe_n[i]) pulses++;
    end
    chk("abort_no_ack", n_ack, 0);
    chk("abort_pulse_len", pulses, w);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = '0; sel[i] = '0; dat_w[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_strobes", {25'd0, ce_n[i], oe_n[i], we_n[i], lb_n[i], ub_n[i], d_oe[i], ack[i]},
          {25'd0, 7'b1111100});
      chk("rst_rdata", {16'd0, dat_r[i]}, 32'd0);
      chk("rst_addr", {14'd0, sram_a[i]}, 32'd0);
      chk("rst_wdata", {16'd0, sram_do[i]}, 32'd0);
    end

    access(0, 2, 1'b1, 18'h12345, 2'b11, 16'hBEEF, 16'h0000);
    access(0, 2, 1'b0, 18'h12345, 2'b11, 16'h0000, 16'hBEEF);
    access(0, 2, 1'b0, 18'h12345, 2'b01, 16'h0000, 16'h00EF);
    access(0, 2, 1'b0, 18'h12345, 2'b10, 16'h0000, 16'hBE00);
    access(0, 2, 1'b0, 18'h12345, 2'b00, 16'h0000, 16'h0000);

    access(0, 2, 1'b1, 18'h00010, 2'b01, 16'hA55A, 16'h0000);
    access(0, 2, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'h005A);
    access(0, 2, 1'b1, 18'h00010, 2'b00, 16'hFFFF, 16'h0000);
    access(0, 2, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'h005A);

    access(0, 2, 1'b1, 18'h3FFFF, 2'b11, 16'h1234, 16'h0000);
    chk("b2b_gap_ce_high", {31'd0, ce_n[0]}, 32'd1);
    access(0, 2, 1'b0, 18'h3FFFF, 2'b11, 16'h0000, 16'h1234);

    abort_read(0, 2, 18'h12345);
    access(0, 2, 1'b0, 18'h3FFFF, 2'b11, 16'h0000, 16'h1234);

    access(1, 1, 1'b1, 18'h00020, 2'b11, 16'hC3C3, 16'h0000);
    access(1, 1, 1'b0, 18'h00020, 2'b11, 16'h0000, 16'hC3C3);
    access(2, 15, 1'b1, 18'h00020, 2'b11, 16'h7E81, 16'h0000);
    access(2, 15, 1'b0, 18'h00020, 2'b11, 16'h0000, 16'h7E81);

    begin : rst_mid_write
      logic in_wp;
      int   n_ack;
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 18'h00055;
      sel[0] = 2'b11; dat_w[0] = 16'h9999;
      @(posedge clk);
      in_wp = 1'b0;
      for (int k = 0; k < 10 && !in_wp; k++) begin
        @(negedge clk);
        if (!we_n[0]) in_wp = 1'b1;
      end
      chk("reached_wp", {31'd0, in_wp}, 32'd1);
      rst = 1'b1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_wp_we_n", {31'd0, we_n[0]}, 32'd1);
      chk("rst_wp_ce_n", {31'd0, ce_n[0]}, 32'd1);
      chk("rst_wp_d_oe", {31'd0, d_oe[0]}, 32'd0);
      chk("rst_wp_ack", {31'd0, ack[0]}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_ack = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (ack[0]) n_ack++;
      end
      chk("rst_wp_no_ack", n_ack, 0);
    end

    access(0, 2, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'h0000);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, SRAM access/write-pulse length in clk_i cycles, legal range 1..15.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset:
  clk_i  in  1  system clock, all logic on rising edge
  rst_i  in  1  synchronous active-high reset
  wb_cyc_i  in  1  Wishbone cycle valid
  wb_stb_i  in  1  Wishbone strobe
  wb_we_i  in  1  1 = write, 0 = read
  wb_adr_i  in  18  16-bit-word address
  wb_sel_i  in  2  byte select, bit0 = D[7:0], bit1 = D[15:8]
  wb_dat_i  in  16  write data
  wb_dat_o  out  16  read data, valid with wb_ack_o
  wb_ack_o  out  1  single-cycle acknowledge
  sram_a_o  out  18  SRAM address
  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o  out  1 each  active-low SRAM strobes
  sram_d_o  out  16  SRAM write data
  sram_d_oe_o  out  1  SRAM data-bus drive enable (tristate resolved at top level)
  sram_d_i  in  16  SRAM read data
REQ-003 All outputs SHALL be driven directly from flops; no combinational path from any input to any output.

Function
REQ-010 States: IDLE, RD, WS (write setup), WP (write pulse), WH (write hold), RACK (read ack).
REQ-011 IDLE: CE_n/OE_n/WE_n/LB_n/UB_n = 1, d_oe = 0, ack = 0; on cyc&stb&!ack, register adr, sel, dat_i and go RD (we=0) or WS (we=1).
REQ-012 RD: CE_n=0, OE_n=0, LB_n=!sel[0], UB_n=!sel[1], held exactly WAIT_CYCLES cycles; last RD cycle captures sram_d_i into wb_dat_o, unselected byte forced to 0x00; then RACK.
REQ-013 RACK: all strobes inactive, ack=1 for one cycle; -> IDLE.
REQ-014 WS: CE_n=0, WE_n=1, byte enables per sel, d_oe=1, sram_d_o = latched data; one cycle; -> WP.
REQ-015 WP: as WS but WE_n=0 for exactly WAIT_CYCLES cycles; -> WH.
REQ-016 WH: WE_n=1, CE_n=0, d_oe=1, data stable, ack=1 for one cycle; -> IDLE (CE_n=1, d_oe=0 next cycle).
REQ-017 Latency from the edge sampling the request in IDLE: read ack at +WAIT_CYCLES+1, write ack at +WAIT_CYCLES+2.
REQ-018 sram_a_o, byte enables and sram_d_o SHALL stay constant from first active cycle until CE_n returns high.
REQ-019 OE_n and WE_n SHALL never be low simultaneously; d_oe SHALL never be 1 while OE_n=0.
REQ-020 wb_sel_i = 0: full SRAM cycle with LB_n=UB_n=1 (no byte written; read returns 0x0000), normal ack.
REQ-021 Abort: if wb_cyc_i is low in any non-IDLE state, the SRAM cycle SHALL complete with normal timing but ack SHALL be suppressed in RACK/WH.
REQ-022 Back-to-back: a request present in the cycle after ack is accepted from IDLE; minimum one idle cycle (CE_n=1) between accesses.
REQ-023 Inputs SHALL be ignored outside IDLE; wb_dat_o holds its value until the next read capture.

Reset
REQ-030 rst_i SHALL, on the next rising edge from any state, force IDLE, all SRAM strobes = 1, d_oe = 0, ack = 0, wait counter = 0, wb_dat_o = 0x0000, sram_a_o = 0, sram_d_o = 0.
REQ-031 Reset asserted mid-write SHALL end the WE_n pulse on that edge with no ack ever issued for the aborted access.

Verification
REQ-040 Read, WAIT_CYCLES=2, adr=0x12345, sel=2'b11, model drives 0xBEEF -> OE_n low 2 cycles, ack 3 cycles after request, wb_dat_o=0xBEEF.
REQ-041 Write, adr=0x00010, sel=2'b01, dat=0xA55A -> WE_n low exactly 2 cycles, LB_n=0, UB_n=1, ack at +4; readback returns 0x005A.
REQ-042 Back-to-back write 0x1234 @0x3FFFF then read @0x3FFFF -> one CE_n-high cycle between, read data 0x1234.
REQ-043 Drop wb_cyc_i during RD -> SRAM cycle completes, no ack, next request serviced normally.
REQ-044 Assert rst_i in WP -> next edge WE_n=1, CE_n=1, d_oe=0, ack never asserts.
REQ-045 WAIT_CYCLES=1 and 15 -> read ack at +2/+16, write ack at +3/+17; OE_n/WE_n overlap never observed (assertion).
